// File: rtl/vedic_multiplier_32x32_pkg.sv
// ---------------------------------------------------------------------------
// vedic_multiplier_32x32_pkg
// Purpose : shared width constants for the 32x32 -> 64 unsigned Vedic
//           multiplier slice.
// Contents: OPERAND_W (operand width), PRODUCT_W (product width).
// ---------------------------------------------------------------------------
package vedic_multiplier_32x32_pkg;

  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;

endpackage : vedic_multiplier_32x32_pkg

// File: rtl/vedic_multiplier_32x32_if.sv
// ---------------------------------------------------------------------------
// vedic_multiplier_32x32_if
// Purpose : groups the operand/product bus of the multiplier.
// Signals : a [31:0] multiplicand, b [31:0] multiplier, c [63:0] product.
// Modports: master drives a/b and observes c; slave (the multiplier)
//           consumes a/b and drives c.
// ---------------------------------------------------------------------------
interface vedic_multiplier_32x32_if;
  import vedic_multiplier_32x32_pkg::*;

  logic [OPERAND_W-1:0] a;
  logic [OPERAND_W-1:0] b;
  logic [PRODUCT_W-1:0] c;

  modport master (output a, output b, input c);
  modport slave  (input a, input b, output c);

endinterface : vedic_multiplier_32x32_if

// File: rtl/vedic_multiplier_32x32_vedic_16x16.sv
// ---------------------------------------------------------------------------
// vedic_16x16
// Purpose : combinational unsigned 16x16 -> 32 Urdhva-Tiryagbhyam
//           multiplier. Recurses 16 -> 8 -> 4 -> 2; the 2x2 leaf is AND
//           gates plus two half adders.
// Ports   : x [15:0] operand, y [15:0] operand, p [31:0] product x*y.
// ---------------------------------------------------------------------------
module vedic_16x16
  import vedic_multiplier_32x32_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);

  // 2x2 leaf: four partial-product ANDs, then two half adders ripple
  // the crosswise sum into bits 2 and 3.
  function automatic logic [3:0] mul2(input logic [1:0] u, input logic [1:0] v);
    logic t1, t2, t3, c1;
    t1 = u[1] & v[0];
    t2 = u[0] & v[1];
    t3 = u[1] & v[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, u[0] & v[0]};
  endfunction

  // Each level: low half of q0 passes straight through; the middle sum is
  // kept two bits wider than a partial product so no carry is lost, and the
  // upper part is q3 shifted by one half plus the middle sum.
  function automatic logic [7:0] mul4(input logic [3:0] u, input logic [3:0] v);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] mid, hi;
    q0  = mul2(u[1:0], v[1:0]);
    q1  = mul2(u[3:2], v[1:0]);
    q2  = mul2(u[1:0], v[3:2]);
    q3  = mul2(u[3:2], v[3:2]);
    mid = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};
    hi  = {q3, 2'b00} + mid;
    return {hi, q0[1:0]};
  endfunction

  function automatic logic [15:0] mul8(input logic [7:0] u, input logic [7:0] v);
    logic [7:0]  q0, q1, q2, q3;
    logic [9:0]  mid;
    logic [11:0] hi;
    q0  = mul4(u[3:0], v[3:0]);
    q1  = mul4(u[7:4], v[3:0]);
    q2  = mul4(u[3:0], v[7:4]);
    q3  = mul4(u[7:4], v[7:4]);
    mid = {2'b00, q1} + {2'b00, q2} + {6'b000000, q0[7:4]};
    hi  = {q3, 4'h0} + {2'b00, mid};
    return {hi, q0[3:0]};
  endfunction

  logic [15:0] q0_s, q1_s, q2_s, q3_s;
  logic [17:0] mid_s;
  logic [23:0] hi_s;

  assign q0_s  = mul8(x[7:0],  y[7:0]);
  assign q1_s  = mul8(x[15:8], y[7:0]);
  assign q2_s  = mul8(x[7:0],  y[15:8]);
  assign q3_s  = mul8(x[15:8], y[15:8]);
  assign mid_s = {2'b00, q1_s} + {2'b00, q2_s} + {10'd0, q0_s[15:8]};
  assign hi_s  = {q3_s, 8'h00} + {6'd0, mid_s};
  assign p     = {hi_s, q0_s[7:0]};

endmodule : vedic_16x16

// File: rtl/vedic_multiplier_32x32.sv
// ---------------------------------------------------------------------------
// vedic_multiplier_32x32
// Purpose : unsigned 32x32 -> 64 Vedic multiplier with one registered
//           output stage (latency 1, one product per cycle).
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset, clears the product
//           bus  - slave side: a/b operands in, c registered product out
// ---------------------------------------------------------------------------
module vedic_multiplier_32x32
  import vedic_multiplier_32x32_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  vedic_multiplier_32x32_if.slave  bus
);

  logic [31:0]          q0_s, q1_s, q2_s, q3_s;
  logic [33:0]          mid_s;
  logic [47:0]          hi_s;
  logic [PRODUCT_W-1:0] product_s;
  logic [PRODUCT_W-1:0] c_r;

  vedic_16x16 u_q0 (.x(bus.a[15:0]),  .y(bus.b[15:0]),  .p(q0_s));
  vedic_16x16 u_q1 (.x(bus.a[31:16]), .y(bus.b[15:0]),  .p(q1_s));
  vedic_16x16 u_q2 (.x(bus.a[15:0]),  .y(bus.b[31:16]), .p(q2_s));
  vedic_16x16 u_q3 (.x(bus.a[31:16]), .y(bus.b[31:16]), .p(q3_s));

  // Middle sum is 34 bits so both crosswise carries survive; the upper
  // 48 bits then absorb it on top of q3 shifted up one half.
  assign mid_s     = {2'b00, q1_s} + {2'b00, q2_s} + {18'd0, q0_s[31:16]};
  assign hi_s      = {q3_s, 16'h0000} + {14'd0, mid_s};
  assign product_s = {hi_s, q0_s[15:0]};

  // Output register: reset drops whatever operands were sampled this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_r <= {PRODUCT_W{1'b0}};
    end else begin
      c_r <= product_s;
    end
  end

  assign bus.c = c_r;

endmodule : vedic_multiplier_32x32

// File: tb/tb_vedic_multiplier_32x32.sv
// ---------------------------------------------------------------------------
// tb_vedic_multiplier_32x32
// Purpose : self-checking bench for vedic_multiplier_32x32 -- reset,
//           directed small/sign-magnitude/extreme vectors, then a random
//           back-to-back stream with a single-cycle reset mid-stream.
// ---------------------------------------------------------------------------
module tb_vedic_multiplier_32x32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vedic_multiplier_32x32_if bus ();

  vedic_multiplier_32x32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare the registered product against the expected value.
  task automatic check(input string tag, input logic [63:0] expected);
    checks++;
    assert (bus.c === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.c, expected);
    end
  endtask

  // Present one operand pair, let one edge capture it, then check.
  task automatic step(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [63:0] expected);
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  // Directed sequence followed by the random stream.
  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.a    = 32'd5;
    bus.b    = 32'd7;

    // Reset: operands 5,7 sampled under reset are dropped.
    @(posedge clk);
    #1;
    check("reset", 64'd0);
    rst = 1'b0;
    step("after_reset", 32'd5, 32'd7, 64'd35);

    // Small sequence.
    step("1x0",    32'd1,  32'd0,   64'd0);
    step("3x3",    32'd3,  32'd3,   64'd9);
    step("6x7",    32'd6,  32'd7,   64'd42);
    step("10x12",  32'd10, 32'd12,  64'd120);
    step("55x63",  32'd55, 32'd63,  64'd3465);
    step("64x81",  32'd64, 32'd81,  64'd5184);
    step("83x119", 32'd83, 32'd119, 64'd9877);

    // Magnitudes the caller would negate afterwards.
    step("mag_11x12",  32'd11,         32'd12, 64'd132);
    step("mag_max_s",  32'd2147483647, 32'd1,  64'd2147483647);

    // Extremes.
    step("max_x_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    step("msb_x2",     32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000);
    step("half_carry", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    step("zero_x_max", 32'd0,         32'hFFFF_FFFF, 64'd0);
    step("max_x_1",    32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF);
    step("mid_cross",  32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000);

    // Random back-to-back stream with a one-cycle reset at the midpoint.
    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rexp = {32'd0, ra} * {32'd0, rb};
      if (i == 5000) begin
        rst = 1'b1;
        step("rand_reset_slot", ra, rb, 64'd0);
        rst = 1'b0;
      end else begin
        step("rand", ra, rb, rexp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vedic_multiplier_32x32
